frame_src_arbiter: RTL and testbench

FRAME_SRC_ARBITER -- requirements
Module: frame_src_arbiter

---
 rtl/fb_pkg.sv | 16 +
 rtl/frame_src_arbiter.sv | 148 ++++++++++++++
 tb/tb_frame_src_arbiter.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/fb_pkg.sv
// Shared frame-buffer constants and the source-arbiter state encoding.
package fb_pkg;

  localparam int unsigned FB_FRAME_PIXELS = 40800;
  localparam int unsigned FB_ADDR_W       = 16;
  localparam int unsigned FB_RGB_W        = 24;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_UART = 3'd1,
    S_CAM  = 3'd2,
    S_DONE = 3'd3,
    S_LOCK = 3'd4
  } state_t;

endpackage

// File: rtl/frame_src_arbiter.sv
// Selects UART or camera pixel writes into the frame buffer, whole frames at a time,
// with a plotter lock handshake. Define FB_ADDR_CHECK_EN to drop out-of-range writes.
module frame_src_arbiter
  import fb_pkg::*;
#(
  parameter int unsigned FRAME_PIXELS = FB_FRAME_PIXELS,
  parameter int unsigned ADDR_W       = FB_ADDR_W,
  parameter int unsigned RGB_W        = FB_RGB_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              mode_req,
  input  logic              uart_we,
  input  logic [ADDR_W-1:0] uart_addr,
  input  logic [RGB_W-1:0]  uart_rgb,
  input  logic              uart_frame_done,
  input  logic              cam_we,
  input  logic [ADDR_W-1:0] cam_addr,
  input  logic [RGB_W-1:0]  cam_rgb,
  input  logic              cam_frame_done,
  input  logic              lock_req,
  output logic              lock_ack,
  output logic              fb_we,
  output logic [ADDR_W-1:0] fb_addr,
  output logic [RGB_W-1:0]  fb_wdata,
  output logic              cam_mode,
  output logic              frame_ready,
  output logic [7:0]        frame_cnt,
  output logic              addr_err
);

  if (FRAME_PIXELS == 0 || 64'(FRAME_PIXELS) > (64'd1 << ADDR_W)) begin : g_bad_cfg
    $error("FRAME_PIXELS must be in 1..2**ADDR_W");
  end

  state_t            r_state;
  state_t            w_state_next;
  logic              w_sel_we;
  logic [ADDR_W-1:0] w_sel_addr;
  logic [RGB_W-1:0]  w_sel_rgb;
  logic              w_sel_done;
  logic              w_addr_ok;
  logic              w_fwd;

  logic              r_fb_we;
  logic [ADDR_W-1:0] r_fb_addr;
  logic [RGB_W-1:0]  r_fb_wdata;
  logic              r_cam_mode;
  logic              r_frame_ready;
  logic [7:0]        r_frame_cnt;
  logic              r_lock_ack;

  // Only the source owning the current frame reaches the buffer; IDLE/DONE/LOCK drop all writes.
  always_comb begin
    w_sel_we   = 1'b0;
    w_sel_addr = uart_addr;
    w_sel_rgb  = uart_rgb;
    w_sel_done = 1'b0;
    case (r_state)
      S_UART: begin
        w_sel_we   = uart_we;
        w_sel_done = uart_frame_done;
      end
      S_CAM: begin
        w_sel_we   = cam_we;
        w_sel_addr = cam_addr;
        w_sel_rgb  = cam_rgb;
        w_sel_done = cam_frame_done;
      end
      default: ;
    endcase
  end

`ifdef FB_ADDR_CHECK_EN
  logic r_addr_err;

  assign w_addr_ok = 32'(w_sel_addr) < FRAME_PIXELS;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_addr_err <= 1'b0;
    end else if (w_sel_we && !w_addr_ok) begin
      r_addr_err <= 1'b1;
    end
  end

  assign addr_err = r_addr_err;
`else
  assign w_addr_ok = 1'b1;
  assign addr_err  = 1'b0;
`endif

  assign w_fwd = w_sel_we & w_addr_ok;

  // A lock request is only honoured from IDLE, so an in-flight frame always completes first.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (lock_req)      w_state_next = S_LOCK;
        else if (mode_req) w_state_next = S_CAM;
        else               w_state_next = S_UART;
      end
      S_UART,
      S_CAM:   if (w_sel_done) w_state_next = S_DONE;
      S_DONE:  w_state_next = S_IDLE;
      S_LOCK:  if (!lock_req) w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_fb_we       <= 1'b0;
      r_fb_addr     <= '0;
      r_fb_wdata    <= '0;
      r_cam_mode    <= 1'b0;
      r_frame_ready <= 1'b0;
      r_frame_cnt   <= 8'd0;
      r_lock_ack    <= 1'b0;
    end else begin
      r_state       <= w_state_next;
      r_fb_we       <= w_fwd;
      r_frame_ready <= (w_state_next == S_DONE);
      r_lock_ack    <= (w_state_next == S_LOCK);
      if (w_fwd) begin
        r_fb_addr  <= w_sel_addr;
        r_fb_wdata <= w_sel_rgb;
      end
      if (r_state == S_IDLE && !lock_req) begin
        r_cam_mode <= mode_req;
      end
      if (w_state_next == S_DONE) begin
        r_frame_cnt <= r_frame_cnt + 8'd1;
      end
    end
  end

  assign fb_we       = r_fb_we;
  assign fb_addr     = r_fb_addr;
  assign fb_wdata    = r_fb_wdata;
  assign cam_mode    = r_cam_mode;
  assign frame_ready = r_frame_ready;
  assign frame_cnt   = r_frame_cnt;
  assign lock_ack    = r_lock_ack;

endmodule

// File: tb/tb_frame_src_arbiter.sv
// Scoreboard bench for frame_src_arbiter: expected buffer writes are queued at drive
// time and matched (cycle, address, data) as fb_we pulses appear.
module tb_frame_src_arbiter;
  import fb_pkg::*;

  localparam int AW = FB_ADDR_W;
  localparam int RW = FB_RGB_W;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          mode_req = 1'b0;
  logic          uart_we = 1'b0;
  logic [AW-1:0] uart_addr = '0;
  logic [RW-1:0] uart_rgb = '0;
  logic          uart_frame_done = 1'b0;
  logic          cam_we = 1'b0;
  logic [AW-1:0] cam_addr = '0;
  logic [RW-1:0] cam_rgb = '0;
  logic          cam_frame_done = 1'b0;
  logic          lock_req = 1'b0;
  logic          lock_ack;
  logic          fb_we;
  logic [AW-1:0] fb_addr;
  logic [RW-1:0] fb_wdata;
  logic          cam_mode;
  logic          frame_ready;
  logic [7:0]    frame_cnt;
  logic          addr_err;

  frame_src_arbiter dut (
    .clk(clk), .reset(reset), .mode_req(mode_req),
    .uart_we(uart_we), .uart_addr(uart_addr), .uart_rgb(uart_rgb),
    .uart_frame_done(uart_frame_done),
    .cam_we(cam_we), .cam_addr(cam_addr), .cam_rgb(cam_rgb),
    .cam_frame_done(cam_frame_done),
    .lock_req(lock_req), .lock_ack(lock_ack),
    .fb_we(fb_we), .fb_addr(fb_addr), .fb_wdata(fb_wdata),
    .cam_mode(cam_mode), .frame_ready(frame_ready), .frame_cnt(frame_cnt),
    .addr_err(addr_err)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int unsigned   cyc;
    logic [AW-1:0] addr;
    logic [RW-1:0] data;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   exp_cnt = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (fb_we === 1'b1) begin
      if (sb_q.size() == 0) begin
        check_val("fb_we_unexpected", 32'(fb_we), 32'd0);
      end else begin
        mon_e = sb_q.pop_front();
        $display("[TB] fb write cyc=%0d addr=%0d data=0x%06h", cyc, fb_addr, fb_wdata);
        check_val("fb_cycle", cyc, mon_e.cyc);
        check_val("fb_addr", 32'(fb_addr), 32'(mon_e.addr));
        check_val("fb_wdata", 32'(fb_wdata), 32'(mon_e.data));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_wr(input logic [AW-1:0] a, input logic [RW-1:0] d);
    exp_t e;
    e.cyc  = cyc + 1;
    e.addr = a;
    e.data = d;
    sb_q.push_back(e);
  endtask

  task automatic drive_uart(input logic [AW-1:0] a, input logic [RW-1:0] d, input bit fwd);
    uart_we = 1'b1; uart_addr = a; uart_rgb = d;
    if (fwd) expect_wr(a, d);
  endtask

  task automatic drive_cam(input logic [AW-1:0] a, input logic [RW-1:0] d, input bit fwd);
    cam_we = 1'b1; cam_addr = a; cam_rgb = d;
    if (fwd) expect_wr(a, d);
  endtask

  task automatic idle_writes();
    uart_we = 1'b0; cam_we = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check_val({tag, "_fb_we"}, 32'(fb_we), 32'd0);
    check_val({tag, "_fb_addr"}, 32'(fb_addr), 32'd0);
    check_val({tag, "_fb_wdata"}, 32'(fb_wdata), 32'd0);
    check_val({tag, "_cam_mode"}, 32'(cam_mode), 32'd0);
    check_val({tag, "_frame_ready"}, 32'(frame_ready), 32'd0);
    check_val({tag, "_frame_cnt"}, 32'(frame_cnt), 32'd0);
    check_val({tag, "_addr_err"}, 32'(addr_err), 32'd0);
    check_val({tag, "_lock_ack"}, 32'(lock_ack), 32'd0);
  endtask

  initial begin
    logic exp_err;
    // reset state
    tick(); tick();
    check_all_zero("reset");

    // three UART writes then end of frame
    reset = 1'b0;
    tick();
    drive_uart(16'd0, 24'hFF0000, 1'b1); tick();
    drive_uart(16'd1, 24'hFF0000, 1'b1); tick();
    drive_uart(16'd40799, 24'hFF0000, 1'b1); tick();
    idle_writes(); uart_frame_done = 1'b1;
    tick();
    exp_cnt = 1;
    check_val("f1_frame_ready", 32'(frame_ready), 32'd1);
    check_val("f1_frame_cnt", 32'(frame_cnt), 32'(exp_cnt));
    check_val("f1_fb_we_low", 32'(fb_we), 32'd0);
    check_val("f1_fb_addr_hold", 32'(fb_addr), 32'd40799);
    check_val("f1_fb_wdata_hold", 32'(fb_wdata), 32'hFF0000);
    uart_frame_done = 1'b0;
    tick();
    check_val("f1_ready_one_cycle", 32'(frame_ready), 32'd0);

    // mode change mid-frame, foreign writes and foreign frame_done ignored
    tick();
    mode_req = 1'b1;
    drive_uart(16'd10, 24'h00AA11, 1'b1);
    drive_cam(16'd9, 24'h123456, 1'b0);
    cam_frame_done = 1'b1;
    tick();
    idle_writes(); cam_frame_done = 1'b0;
    check_val("m_cam_mode_hold", 32'(cam_mode), 32'd0);
    check_val("m_no_ready_foreign_done", 32'(frame_ready), 32'd0);
    drive_uart(16'd11, 24'h00BB22, 1'b1);
    uart_frame_done = 1'b1;
    tick();
    idle_writes(); uart_frame_done = 1'b0;
    exp_cnt = 2;
    check_val("m_frame_ready", 32'(frame_ready), 32'd1);
    check_val("m_frame_cnt", 32'(frame_cnt), 32'(exp_cnt));
    check_val("m_cam_mode_done", 32'(cam_mode), 32'd0);
    tick();
    check_val("m_cam_mode_idle", 32'(cam_mode), 32'd0);
    tick();
    check_val("m_cam_mode_set", 32'(cam_mode), 32'd1);
    drive_cam(16'd300, 24'h0000FF, 1'b1);
    drive_uart(16'd301, 24'hABCDEF, 1'b0);
    tick();
    idle_writes(); cam_frame_done = 1'b1;
    tick();
    cam_frame_done = 1'b0;
    exp_cnt = 3;
    check_val("m_cam_frame_cnt", 32'(frame_cnt), 32'(exp_cnt));
    tick();

    // lock requested mid-frame
    mode_req = 1'b0;
    tick();
    check_val("l_cam_mode", 32'(cam_mode), 32'd0);
    lock_req = 1'b1;
    drive_uart(16'd20, 24'h112233, 1'b1);
    tick();
    idle_writes();
    check_val("l_ack_midframe", 32'(lock_ack), 32'd0);
    uart_frame_done = 1'b1;
    tick();
    uart_frame_done = 1'b0;
    exp_cnt = 4;
    check_val("l_ack_in_done", 32'(lock_ack), 32'd0);
    check_val("l_frame_ready", 32'(frame_ready), 32'd1);
    tick();
    check_val("l_ack_in_idle", 32'(lock_ack), 32'd0);
    tick();
    check_val("l_ack_set", 32'(lock_ack), 32'd1);
    drive_uart(16'd21, 24'h445566, 1'b0);
    drive_cam(16'd22, 24'h778899, 1'b0);
    tick();
    idle_writes();
    check_val("l_ack_held", 32'(lock_ack), 32'd1);
    check_val("l_fb_we_locked", 32'(fb_we), 32'd0);
    lock_req = 1'b0;
    tick();
    check_val("l_ack_release", 32'(lock_ack), 32'd0);
    tick();

    // out-of-range address
`ifdef FB_ADDR_CHECK_EN
    exp_err = 1'b1;
`else
    exp_err = 1'b0;
`endif
    drive_uart(16'd40800, 24'hDEAD01, !exp_err);
    tick();
    idle_writes();
    check_val("a_fb_we", 32'(fb_we), 32'(!exp_err));
    check_val("a_addr_err", 32'(addr_err), 32'(exp_err));
    drive_uart(16'd5, 24'h050505, 1'b1);
    tick();
    idle_writes();
    check_val("a_addr_err_sticky", 32'(addr_err), 32'(exp_err));
    cam_frame_done = 1'b1;
    tick();
    check_val("a_foreign_done_1", 32'(frame_ready), 32'd0);
    tick();
    cam_frame_done = 1'b0;
    check_val("a_foreign_done_2", 32'(frame_ready), 32'd0);
    uart_frame_done = 1'b1;
    tick();
    uart_frame_done = 1'b0;
    exp_cnt = 5;
    check_val("a_frame_cnt", 32'(frame_cnt), 32'(exp_cnt));
    tick();

    // 256 frames: counter wraps 255 -> 0
    for (int f = 0; f < 256; f++) begin
      tick();
      uart_frame_done = 1'b1;
      tick();
      uart_frame_done = 1'b0;
      exp_cnt = (exp_cnt + 1) % 256;
      check_val((exp_cnt == 0) ? "w_frame_cnt_wrap" : "w_frame_cnt",
                32'(frame_cnt), 32'(exp_cnt));
      check_val("w_frame_ready", 32'(frame_ready), 32'd1);
      tick();
    end

    // reset mid-frame after 10 writes
    tick();
    for (int i = 0; i < 10; i++) begin
      drive_uart(16'(100 + i), 24'(32'h010101 * (i + 1)), 1'b1);
      tick();
    end
    idle_writes();
    reset = 1'b1;
    uart_frame_done = 1'b1;
    tick();
    check_all_zero("rst_mid");
    reset = 1'b0;
    drive_uart(16'd7, 24'h777777, 1'b0);
    tick();
    idle_writes(); uart_frame_done = 1'b0;
    check_val("rst_no_ready", 32'(frame_ready), 32'd0);
    check_val("rst_idle_write_dropped", 32'(fb_we), 32'd0);
    check_val("rst_frame_cnt", 32'(frame_cnt), 32'd0);
    tick();
    check_val("rst_no_ready_2", 32'(frame_ready), 32'd0);
    tick();
    check_val("sb_empty", 32'(sb_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
